// File: rtl/restoring_div_seq_pkg.sv
// Shared definitions for the restoring divider.
//   DW_DEFAULT : default operand width
//   state_e    : controller state encoding (IDLE / ITER / DONE)
package restoring_div_seq_pkg;

  localparam int unsigned DW_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/restoring_div_seq_mux.sv
// Restore select for the restoring divider: a plain 2:1 word mux.
//   i_a   : restore path (shifted partial remainder)
//   i_b   : subtract path (trial difference)
//   i_sel : borrow from the trial subtraction; high selects i_a
//   o_y   : selected word
module mux_2_1 #(
  parameter int unsigned DataWidth = 4
) (
  input  logic [DataWidth-1:0] i_a,
  input  logic [DataWidth-1:0] i_b,
  input  logic                 i_sel,
  output logic [DataWidth-1:0] o_y
);

  always_comb begin
    o_y = i_b;
    if (i_sel) begin
      o_y = i_a;
    end
  end

endmodule

// File: rtl/restoring_div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : request, accepted only in IDLE or DONE
//   i_dividend/divisor  : operands, sampled with an accepted start
//   o_busy              : high while iterating
//   o_done              : one-cycle pulse, results valid from this cycle
//   o_quotient/remainder: results, held until the next accepted start
//   o_div_by_zero       : set with done when divisor was zero
module restoring_div_seq
  import restoring_div_seq_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_quotient,
  output logic [DW-1:0] o_remainder,
  output logic          o_div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DW + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_q;
  logic [DW-1:0]    r_m;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_quot;
  logic [DW-1:0]    r_rem;
  logic             r_dbz;

  logic             w_ready;
  logic             w_accept;
  logic             w_zero_div;
  logic             w_last;
  logic [DW:0]      w_a_shift;
  logic [DW:0]      w_diff;
  logic             w_borrow;
  logic [DW-1:0]    w_a_next;
  logic [DW-1:0]    w_q_next;

  assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept   = i_start && w_ready;
  assign w_zero_div = (i_divisor == '0);
  assign w_last     = (r_cnt == LAST_CNT);

  // Trial subtraction on the shifted {A,Q} pair; the top bit is the borrow.
  assign w_a_shift = {r_a, r_q[DW-1]};
  assign w_diff    = w_a_shift - {1'b0, r_m};
  assign w_borrow  = w_diff[DW];

  // A < M holds between iterations, so dropping the top bit of either input loses nothing.
  mux_2_1 #(
    .DataWidth(DW)
  ) u_restore_mux (
    .i_a  (w_a_shift[DW-1:0]),
    .i_b  (w_diff[DW-1:0]),
    .i_sel(w_borrow),
    .o_y  (w_a_next)
  );

  assign w_q_next = {r_q[DW-2:0], ~w_borrow};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_next = w_zero_div ? ST_DONE : ST_ITER;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a   <= '0;
        r_q   <= i_dividend;
        r_m   <= i_divisor;
        r_cnt <= '0;
        // Zero divisor skips the iterations and publishes results right away.
        if (w_zero_div) begin
          r_quot <= '1;
          r_rem  <= i_dividend;
          r_dbz  <= 1'b1;
        end
      end else if (r_state == ST_ITER) begin
        r_a   <= w_a_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_quot <= w_q_next;
          r_rem  <= w_a_next;
          r_dbz  <= 1'b0;
        end
      end
    end
  end

  assign o_busy        = (r_state == ST_ITER);
  assign o_done        = (r_state == ST_DONE);
  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dbz;

endmodule
